regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file for the next-generation MIPS datapath. It provides NREAD asynchronous read ports and two synchronous write ports (writeback plus a second retire path), with optional write-to-read bypass and a hardwired zero register. A per-register busy scoreboard lets the hazard unit stall on pending producers. After reset, a sequential clear sweep runs before the file reports ready, so no large fan-out reset of the array is needed.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NREAD, 2, number of read ports
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes, is never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
- TEST_IDX, 18, entry driven onto test_reg

- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-low
- rd_addr  in  NREAD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, same packing
- wr0_en / wr0_addr / wr0_data  in  1 / ADDR_W / DATA_W  write port 0 (priority)
- wr1_en / wr1_addr / wr1_data  in  1 / ADDR_W / DATA_W  write port 1
- resv_en  in  1  mark resv_addr busy (issue of a producer)
- resv_addr  in  ADDR_W  register being reserved
- busy  out  DEPTH  scoreboard bit per entry
- ready  out  1  high once the clear sweep is complete
- test_reg  out  DATA_W  raw contents of entry TEST_IDX (no bypass)

## Operation
- States: INIT, RUN. Sweep index idx is ADDR_W+1 bits wide.
- Any edge with rst=0: state<=INIT, idx<=0, busy<=0, ready<=0. Array is not written.
- INIT with rst=1: entry[idx]<=0 and idx<=idx+1 each edge. On the edge that clears entry DEPTH-1: state<=RUN, ready<=1.
- During INIT: wr0/wr1/resv are ignored, rd_data=0, busy=0.
- RUN writes: port p commits when wrp_en=1. Both ports write the same address: port 0 data stored. ZERO_REG=1 and address 0: write discarded.
- Reads (combinational), for each port k:
  - ZERO_REG and rd_addr=0 -> 0.
  - Else BYPASS and wr0 commits to rd_addr -> wr0_data.
  - Else BYPASS and wr1 commits to rd_addr -> wr1_data.
  - Else entry[rd_addr].
- Scoreboard, RUN only, per entry r at each edge:
  - Set if resv_en and resv_addr=r.
  - Else cleared if either write commits to r.
  - Else held.
  - Set beats clear when both hit the same r in one cycle (new producer supersedes).
  - With ZERO_REG=1, busy[0] is constant 0 and resv to address 0 is ignored.
- test_reg is always entry[TEST_IDX], including during INIT (shows sweep progress).

## Timing
- Reset outputs: ready=0, busy=all 0, rd_data=0. test_reg holds its prior value until the sweep clears TEST_IDX.
- Sweep latency: ready rises on the DEPTH-th rising edge with rst=1 after the last rst=0 edge (32 edges for defaults).
- Write latency: data visible on the edge after wr*_en. With BYPASS=1 it is also visible in the same cycle on rd_data. With BYPASS=0 it is not visible until that edge.
- Busy latency: busy[r] changes one edge after resv_en or the committing write. busy has no combinational bypass.
- rst=0 mid-RUN: the sweep restarts from idx 0. Array contents persist until swept, but reads return 0 until ready.
- Read path is purely combinational: there is no read enable and no added latency.

## Test plan
- Reset sweep: rst=0 for 3 cycles, then rst=1 -> ready=0 for 31 edges, ready=1 on edge 32, every rd_data=0, busy=0.
- Basic write/read: wr0 addr 16 data 0x4D2, wr1 addr 17 data 0x162E; next cycle rd_addr0=16, rd_addr1=17 -> 0x4D2, 0x162E. Writing addr 18 = 0xABCD -> test_reg=0xABCD after the edge.
- Conflicts: wr0 and wr1 both to addr 5 with 0x1111 and 0x2222 -> entry 5=0x1111. Same-cycle read of 5 with BYPASS=1 -> 0x1111. Write 0xFFFF to addr 0 -> rd_data=0.
- Bypass off (BYPASS=0): write 0x55 to addr 9 over old value 0x33 -> same-cycle read 0x33, next cycle 0x55.
- Scoreboard: resv addr 8 -> busy[8]=1 next edge. wr1 to 8 -> busy[8]=0 next edge. resv 8 and wr0 to 8 in the same cycle -> busy[8] stays 1. resv addr 0 -> busy[0]=0.
- Reset mid-run: fill entries, set busy, pulse rst=0 for 1 cycle -> ready=0, busy=0, reads=0; ready back after 32 edges with all entries 0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with post-reset clear sweep, write bypass and busy scoreboard
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int TEST_IDX = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  input  logic                      wr0_en,
  input  logic [ADDR_W-1:0]         wr0_addr,
  input  logic [DATA_W-1:0]         wr0_data,
  input  logic                      wr1_en,
  input  logic [ADDR_W-1:0]         wr1_addr,
  input  logic [DATA_W-1:0]         wr1_data,
  input  logic                      resv_en,
  input  logic [ADDR_W-1:0]         resv_addr,
  output logic [(1<<ADDR_W)-1:0]    busy,
  output logic                      ready,
  output logic [DATA_W-1:0]         test_reg
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] TEST_A   = ADDR_W'(TEST_IDX);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W:0]   idx, idx_next;
  logic              ready_next;
  logic [DEPTH-1:0]  busy_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr0_go, wr1_go;

  function automatic logic zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A write only "commits" in RUN and outside reset; bypass and scoreboard both key off this.
  assign wr0_go = (state == RUN) && rst && wr0_en && !zero_addr(wr0_addr);
  assign wr1_go = (state == RUN) && rst && wr1_en && !zero_addr(wr1_addr);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    ready_next = ready;
    busy_next  = busy;
    case (state)
      INIT: begin
        idx_next = idx + 1'b1;
        if (idx == LAST_IDX) begin
          state_next = RUN;
          ready_next = 1'b1;
        end
      end
      RUN: begin
        // A new reservation supersedes a retiring write to the same entry.
        for (int r = 0; r < DEPTH; r++) begin
          if (resv_en && (resv_addr == ADDR_W'(r)) && !zero_addr(resv_addr))
            busy_next[r] = 1'b1;
          else if ((wr0_go && (wr0_addr == ADDR_W'(r))) ||
                   (wr1_go && (wr1_addr == ADDR_W'(r))))
            busy_next[r] = 1'b0;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      idx   <= '0;
      ready <= 1'b0;
      busy  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      ready <= ready_next;
      busy  <= busy_next;
    end
  end

  // Array has no reset; the sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) begin
        mem[idx[ADDR_W-1:0]] <= '0;
      end else begin
        if (wr1_go) mem[wr1_addr] <= wr1_data;
        if (wr0_go) mem[wr0_addr] <= wr0_data;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] val;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      val = mem[a];
      if (!ready || zero_addr(a))
        val = '0;
      else if ((BYPASS != 0) && wr0_go && (wr0_addr == a))
        val = wr0_data;
      else if ((BYPASS != 0) && wr1_go && (wr1_addr == a))
        val = wr1_data;
    end
    assign rd_data[k*DATA_W +: DATA_W] = val;
  end

  assign test_reg = mem[TEST_A];

endmodule
